multi_blinky: RTL and testbench
===============================

# multi_blinky

Parametrised N-channel LED blinker, the generalised successor of the two-channel blinker. Channel i toggles its output every clk_freq_hz >> i clock cycles, so each channel blinks twice as fast as the one before it. Each channel has its own run enable and a one-cycle toggle strobe. A global phase-sync input realigns all channels. It sits at board top level between the system clock and status LEDs, and also serves as a multi-rate tick source.

## Interface
- clk_freq_hz, 1_000_000_000: clock frequency in Hz; channel 0 half-period in cycles. Legal range ≥ 2.
- channels, 4: number of output channels. Legal range 1..32.
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  reset, synchronous, active-high; one clock domain only.
- en  input  channels  per-channel run enable, level-sensitive.
- sync  input  1  phase-realign request, single-cycle pulse or level.
- q  output  channels  blink outputs.
- wrap  output  channels  one-cycle strobe, high in the cycle in which q[i] takes its new value.

## Operation
- Per-channel half-period: P_i = max(1, clk_freq_hz >> i), computed at elaboration.
- Per-channel counter: cnt_i, width $clog2(clk_freq_hz), unsigned, never exceeds P_i − 1.
- Each channel is an independent two-state machine, IDLE or RUN. The state is fully determined by en[i]; no extra state register is required.
- Rules per rising edge, in priority order:
  1. rst=1: all cnt_i=0, q=0, wrap=0.
  2. sync=1 (only when the sync feature is compiled in): all cnt_i=0, q=0, wrap=0. Overrides en and any pending toggle.
  3. en[i]=0: cnt_i=0, q[i]=0, wrap[i]=0. The channel goes to IDLE.
  4. en[i]=1 and cnt_i == P_i−1: cnt_i=0, q[i] inverts, wrap[i]=1.
  5. en[i]=1 otherwise: cnt_i increments, wrap[i]=0.
- P_i=1: q[i] toggles on every enabled edge and wrap[i] stays high continuously.
- Channels with index i where clk_freq_hz >> i == 0 saturate at P_i=1. No error is raised.
- Channels never interact, except through rst and sync.

## Timing
- Reset values: q=0, wrap=0, all counters 0.
- All outputs are registered. There is no combinational path from any input to any output.
- First toggle latency: en[i] high on edge k (first edge with en sampled high counts as edge 1).
  - q[i] goes 1 after edge P_i.
  - q[i] returns to 0 after edge 2·P_i.
  - Output period is 2·P_i cycles, 50 % duty.
- Deasserting en[i] forces q[i]=0 and wrap[i]=0 from the next edge. Re-enabling restarts the channel from cnt_i=0 with the full first-toggle latency.
- Simultaneous events:
  - rst and sync together: rst wins. The result is identical either way.
  - sync and a terminal count in the same cycle: sync wins, so no toggle and wrap=0.
- Held sync keeps all channels at 0. Counting resumes on the first edge with sync=0.
- Reset mid-operation takes effect on the next edge regardless of counter state.

## Configuration
- MULTI_BLINKY_SYNC_EN defined: the sync input behaves as in Operation rule 2.
- MULTI_BLINKY_SYNC_EN undefined:
  - The sync port is still present but ignored; no logic is generated for it.
  - Channels realign only through rst or en.

## Test plan
Use clk_freq_hz=8 and channels=4 (P = 8, 4, 2, 1) unless noted.
- Reset: hold rst for 3 edges with en=4'hF → q=0 and wrap=0 throughout and on the first edge after release.
- Rates: en=4'hF from reset release, observe 32 edges →
  - q[0] toggles at edges 8, 16, 24, 32.
  - q[1] toggles every 4 edges.
  - q[2] toggles every 2 edges.
  - q[3] toggles every edge.
  - wrap coincides with each toggle.
- Enable gating: drop en[1] at edge 6 (q[1]=1) → q[1]=0 after edge 7. Re-raise en[1] at edge 10 → next q[1] rise after edge 13.
- Sync (MULTI_BLINKY_SYNC_EN defined): pulse sync at edge 7 with en=4'hF → all q=0 and wrap=0 after edge 7; q[0] next rises after edge 15.
- Sync compiled out: same stimulus → no disturbance; q[0] toggles at edge 8 as in the Rates scenario.
- Saturation: clk_freq_hz=2 and channels=4 (P = 2, 1, 1, 1) → q[1], q[2] and q[3] toggle every edge with wrap held high; q[0] toggles every 2 edges.

Source files
------------

// File: rtl/multi_blinky.sv
// Parametrised N-channel LED blinker: channel i toggles every max(1, clk_freq_hz >> i) cycles.
// Define MULTI_BLINKY_SYNC_EN to make the sync input realign all channels; otherwise it is ignored.
module multi_blinky #(
  parameter int unsigned clk_freq_hz = 1_000_000_000,
  parameter int unsigned channels    = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [channels-1:0] en,
  input  logic                sync,
  output logic [channels-1:0] q,
  output logic [channels-1:0] wrap
);

  localparam int CW = $clog2(clk_freq_hz);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } chan_state_e;

  // Terminal count P_i - 1, with P_i saturating at 1 once the shift runs out of bits.
  function automatic logic [CW-1:0] last_count(input int idx);
    int unsigned p;
    p = clk_freq_hz >> idx;
    if (p == 0) p = 1;
    return CW'(p - 1);
  endfunction

  logic [CW-1:0]       cnt_q [channels];
  logic [CW-1:0]       cnt_d [channels];
  logic [channels-1:0] q_q, q_d;
  logic [channels-1:0] wrap_q, wrap_d;
  chan_state_e         ch_state [channels];

`ifndef MULTI_BLINKY_SYNC_EN
  logic unused_sync;
  assign unused_sync = sync;
`endif

  always_comb begin
    cnt_d  = cnt_q;
    q_d    = q_q;
    wrap_d = '0;
    for (int i = 0; i < int'(channels); i++) begin
      ch_state[i] = en[i] ? RUN : IDLE;
      case (ch_state[i])
        IDLE: begin
          cnt_d[i] = '0;
          q_d[i]   = 1'b0;
        end
        RUN: begin
          if (cnt_q[i] == last_count(i)) begin
            cnt_d[i]  = '0;
            q_d[i]    = ~q_q[i];
            wrap_d[i] = 1'b1;
          end else begin
            cnt_d[i] = cnt_q[i] + 1'b1;
          end
        end
        default: begin
          cnt_d[i] = '0;
          q_d[i]   = 1'b0;
        end
      endcase
    end
`ifdef MULTI_BLINKY_SYNC_EN
    // Sync beats any terminal count landing in the same cycle.
    if (sync) begin
      for (int j = 0; j < int'(channels); j++) cnt_d[j] = '0;
      q_d    = '0;
      wrap_d = '0;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(channels); i++) cnt_q[i] <= '0;
      q_q    <= '0;
      wrap_q <= '0;
    end else begin
      for (int i = 0; i < int'(channels); i++) cnt_q[i] <= cnt_d[i];
      q_q    <= q_d;
      wrap_q <= wrap_d;
    end
  end

  assign q    = q_q;
  assign wrap = wrap_q;

endmodule

// File: tb/tb_multi_blinky.sv
// Self-checking bench for multi_blinky: one instance with P = 8,4,2,1 and one saturated
// instance with P = 2,1,1,1, both driven by the same stimulus and checked every edge.
module tb_multi_blinky;

`ifdef MULTI_BLINKY_SYNC_EN
  localparam bit SYNC_ON = 1'b1;
`else
  localparam bit SYNC_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] en = 4'h0;
  logic       sync = 1'b0;
  logic [3:0] q_a, wrap_a, q_b, wrap_b;

  multi_blinky #(.clk_freq_hz(8), .channels(4)) dut_a (
    .clk(clk), .rst(rst), .en(en), .sync(sync), .q(q_a), .wrap(wrap_a)
  );

  multi_blinky #(.clk_freq_hz(2), .channels(4)) dut_b (
    .clk(clk), .rst(rst), .en(en), .sync(sync), .q(q_b), .wrap(wrap_b)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [3:0] qa, wa, qb, wb;
  } exp_t;

  typedef struct {
    logic       rst;
    logic [3:0] en;
    logic       sync;
    logic [3:0] exp_q;
    logic [3:0] exp_wrap;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[11];
  int   checks = 0;
  int   errors = 0;
  int   run_a[4] = '{0, 0, 0, 0};
  int   run_b[4] = '{0, 0, 0, 0};
  int   per_a[4] = '{8, 4, 2, 1};
  int   per_b[4] = '{2, 1, 1, 1};

  // Reference: each channel's output is a function of how many consecutive enabled edges it has seen.
  task automatic applyStimulus(input logic r, input logic [3:0] e, input logic s, input string name);
    exp_t x;
    rst  = r;
    en   = e;
    sync = s;
    x.name = name;
    for (int i = 0; i < 4; i++) begin
      if (r || (SYNC_ON && s) || !e[i]) begin
        run_a[i] = 0;
        run_b[i] = 0;
      end else begin
        run_a[i]++;
        run_b[i]++;
      end
      x.qa[i] = ((run_a[i] / per_a[i]) % 2) == 1;
      x.wa[i] = (run_a[i] > 0) && (run_a[i] % per_a[i] == 0);
      x.qb[i] = ((run_b[i] / per_b[i]) % 2) == 1;
      x.wb[i] = (run_b[i] > 0) && (run_b[i] % per_b[i] == 0);
    end
    sb.push_back(x);
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput();
    exp_t x;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_empty: no expectation queued");
      return;
    end
    x = sb.pop_front();
    if (q_a !== x.qa || wrap_a !== x.wa) begin
      errors++;
      $display("[TB] FAIL %s dut_a: q=%b wrap=%b expected q=%b wrap=%b", x.name, q_a, wrap_a, x.qa, x.wa);
    end
    checks++;
    if (q_b !== x.qb || wrap_b !== x.wb) begin
      errors++;
      $display("[TB] FAIL %s dut_b: q=%b wrap=%b expected q=%b wrap=%b", x.name, q_b, wrap_b, x.qb, x.wb);
    end
  endtask

  task automatic step(input logic r, input logic [3:0] e, input logic s, input string name);
    applyStimulus(r, e, s, name);
    checkOutput();
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Hand-derived first edges for P = 8,4,2,1 with all channels enabled.
    vecs[0]  = '{1'b1, 4'hF, 1'b0, 4'b0000, 4'b0000};
    vecs[1]  = '{1'b1, 4'hF, 1'b0, 4'b0000, 4'b0000};
    vecs[2]  = '{1'b1, 4'hF, 1'b0, 4'b0000, 4'b0000};
    vecs[3]  = '{1'b0, 4'hF, 1'b0, 4'b1000, 4'b1000};
    vecs[4]  = '{1'b0, 4'hF, 1'b0, 4'b0100, 4'b1100};
    vecs[5]  = '{1'b0, 4'hF, 1'b0, 4'b1100, 4'b1000};
    vecs[6]  = '{1'b0, 4'hF, 1'b0, 4'b0010, 4'b1110};
    vecs[7]  = '{1'b0, 4'hF, 1'b0, 4'b1010, 4'b1000};
    vecs[8]  = '{1'b0, 4'hF, 1'b0, 4'b0110, 4'b1100};
    vecs[9]  = '{1'b0, 4'hF, 1'b0, 4'b1110, 4'b1000};
    vecs[10] = '{1'b0, 4'hF, 1'b0, 4'b0001, 4'b1111};

    $display("[TB] reset and first rate edges");
    for (int v = 0; v < 11; v++) begin
      step(vecs[v].rst, vecs[v].en, vecs[v].sync, $sformatf("vec%0d", v));
      checks++;
      if (q_a !== vecs[v].exp_q || wrap_a !== vecs[v].exp_wrap) begin
        errors++;
        $display("[TB] FAIL table_vec%0d: q=%b wrap=%b expected q=%b wrap=%b",
                 v, q_a, wrap_a, vecs[v].exp_q, vecs[v].exp_wrap);
      end
    end

    $display("[TB] rates through edge 32");
    for (int n = 9; n <= 32; n++) step(1'b0, 4'hF, 1'b0, $sformatf("rate_e%0d", n));

    $display("[TB] enable gating");
    step(1'b1, 4'hF, 1'b0, "gate_rst");
    for (int n = 1; n <= 6; n++) step(1'b0, 4'hF, 1'b0, $sformatf("gate_e%0d", n));
    for (int n = 7; n <= 9; n++) step(1'b0, 4'b1101, 1'b0, $sformatf("gate_off_e%0d", n));
    for (int n = 10; n <= 18; n++) step(1'b0, 4'hF, 1'b0, $sformatf("gate_on_e%0d", n));

    $display("[TB] sync pulse, held sync, sync with reset");
    step(1'b1, 4'hF, 1'b0, "sync_rst");
    for (int n = 1; n <= 6; n++) step(1'b0, 4'hF, 1'b0, $sformatf("sync_e%0d", n));
    step(1'b0, 4'hF, 1'b1, "sync_pulse_e7");
    for (int n = 8; n <= 17; n++) step(1'b0, 4'hF, 1'b0, $sformatf("sync_e%0d", n));
    for (int n = 0; n < 3; n++) step(1'b0, 4'hF, 1'b1, $sformatf("sync_held%0d", n));
    for (int n = 0; n < 5; n++) step(1'b0, 4'hF, 1'b0, $sformatf("sync_resume%0d", n));
    step(1'b1, 4'hF, 1'b1, "rst_and_sync");
    for (int n = 0; n < 3; n++) step(1'b0, 4'hF, 1'b0, $sformatf("after_both%0d", n));

    $display("[TB] reset mid-count");
    step(1'b1, 4'hF, 1'b0, "mid_rst");
    for (int n = 0; n < 4; n++) step(1'b0, 4'hF, 1'b0, $sformatf("mid_after%0d", n));

    $display("[TB] random enables");
    for (int n = 0; n < 60; n++)
      step($urandom_range(0, 19) == 0, 4'($urandom), $urandom_range(0, 9) == 0, $sformatf("rand%0d", n));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
